fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Fetch-stage controller that owns the architectural PC register and sequences instruction-memory reads.
- Issues one request at a time over a req/ready handshake and delivers fetched instructions to decode.
- Handles decode stalls without losing instructions, using a one-entry skid buffer.
- Accepts branch redirects computed by the branch/PC-select logic, including redirects that arrive while a read is still outstanding.
- Stops fetching on a HLT opcode until redirected.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  synchronous active-low reset.
imem_req  out  1  read request; held high until imem_ready.
imem_addr  out  16  read address; stable while imem_req is high.
imem_ready  in  1  read completes this cycle; imem_data is valid.
imem_data  in  16  instruction word.
stall  in  1  decode cannot accept; if_* outputs must hold.
redirect  in  1  taken branch or flush; one-cycle pulse.
redirect_pc  in  16  new fetch address; valid when redirect=1.
if_valid  out  1  if_instr, if_pc and if_pc_inc are valid.
if_instr  out  16  fetched instruction.
if_pc  out  16  address of if_instr.
if_pc_inc  out  16  if_pc + 2, modulo 2^16.
halted  out  1  fetch is stopped on HLT.

Behaviour:
Reset (rst_n=0 at a clk edge):
- pc=RESET_PC, state=IDLE.
- imem_req=0, if_valid=0, skid empty, halted=0.
- if_instr, if_pc, if_pc_inc = 0.
- Reset takes priority over every other input. An outstanding request is abandoned, and the memory model must also reset.

States:
- IDLE: one cycle, no request, then go to FETCH.
- FETCH: imem_req=1, imem_addr=pc.
- DRAIN: imem_req=1 at the old address; the returning data is discarded.
- HALTED: imem_req=0, halted=1.

Handshake:
- A transfer occurs in any cycle with imem_req=1 and imem_ready=1, including the same cycle the request is raised (zero-wait memory).
- imem_req is never withdrawn before ready, even under stall.
- Back-to-back requests are allowed: one fetch per cycle at zero wait.

Capture on a transfer in FETCH:
- The word and pc go to the output regs if the slot is free (if_valid=0 or stall=0); otherwise they go to the skid.
- pc advances to pc+2.
- The next request is issued only while the skid is empty. If the skid is full, imem_req drops after the transfer completes.

Draining the skid:
- When stall=0 and the skid is full, the skid moves into the output regs.
- The skid entry is always delivered before any newer word.

Output register updates:
- if_valid clears when stall=0 and there is no new word to deliver.
- if_pc_inc is registered together with if_pc.

HLT:
- A captured word with instr[15:12]=HALT_OPCODE is delivered normally (if_valid for it).
- After it, state=HALTED, and pc holds the HLT address + 2.

Redirect (priority over everything except reset):
- pc <= redirect_pc.
- if_valid <= 0, skid cleared, halted <= 0.
- Next state:
  - If a request is outstanding and imem_ready=0, go to DRAIN.
  - Otherwise (no request, or ready this cycle with the data dropped), go to FETCH.
- A redirect during DRAIN updates pc and stays in DRAIN.
- In DRAIN, when ready arrives the data is dropped and the state returns to FETCH at pc.
- A redirect in HALTED resumes fetch at redirect_pc.
- redirect with stall=1 still flushes.

Arithmetic:
- pc+2 wraps 16'hFFFE -> 16'h0000.
- redirect_pc[0] is ignored (forced to 0).

Test Plan:
1. Reset, then rst_n=1 with a zero-wait memory -> one IDLE cycle, then imem_req=1. if_pc=0000, 0002, 0004 on consecutive cycles, if_pc_inc=0002, 0004, 0006.
2. 3-cycle-latency memory -> imem_addr=0000 held stable for 3 cycles. if_valid asserts once per 3-4 cycles. No duplicate or skipped PCs.
3. Stall held 4 cycles while a transfer for 0x0004 completes -> if_pc stays 0x0002. The skid holds 0x0004 and imem_req drops. On stall release, 0x0004 and then 0x0006 are delivered in order.
4. redirect with redirect_pc=0x0040 while a read of 0x0008 is outstanding (latency 3) -> DRAIN. The 0x0008 data is never delivered (if_valid=0). The next request and if_pc are 0x0040.
5. Word F000 at 0x0006 -> delivered with if_pc=0x0006, then halted=1 and imem_req stays 0 for 10 cycles. redirect to 0x0020 -> halted=0, next if_pc=0x0020.
6. redirect to 0xFFFE, then two fetches -> if_pc=FFFE, 0000; if_pc_inc=0000, 0002. Separately, rst_n=0 mid-DRAIN -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one imem read at a time, and
// delivers words to decode through an output register backed by a one-entry skid.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_inc,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] pc;

    logic        skid_valid;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;

    logic        xfer;
    logic        capture;
    logic        slot_free;
    logic        is_halt;
    logic [15:0] pc_next;
    logic [15:0] target;

    assign xfer      = imem_req && imem_ready;
    assign capture   = xfer && (state == FETCH);
    assign slot_free = !if_valid || !stall;
    assign is_halt   = (imem_data[15:12] == HALT_OPCODE);
    assign pc_next   = pc + 16'd2;
    assign target    = redirect_pc & 16'hFFFE;

    // Sequencing FSM. imem_req/imem_addr are registered and only change once
    // the current request has completed (or on reset/redirect to a fresh fetch).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            halted    <= 1'b0;
        end else if (redirect) begin
            pc     <= target;
            halted <= 1'b0;
            if (imem_req && !imem_ready) begin
                // Read still in flight: keep it up at its old address and
                // throw the data away when it lands.
                state <= DRAIN;
            end else begin
                state     <= FETCH;
                imem_req  <= 1'b1;
                imem_addr <= target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                FETCH: begin
                    if (capture) begin
                        pc <= pc_next;
                        if (is_halt) begin
                            state    <= HALTED;
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                        end else if (!slot_free) begin
                            imem_req <= 1'b0;
                        end else begin
                            imem_addr <= pc_next;
                        end
                    end else if (!imem_req && !stall) begin
                        // Skid drains this cycle, so fetch can resume next.
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state     <= FETCH;
                        imem_addr <= pc;
                    end
                end
                HALTED: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Output register and skid. The skid is only filled while a request is
    // allowed, which requires it to be empty, so capture and drain never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_valid   <= 1'b0;
            if_instr   <= 16'h0000;
            if_pc      <= 16'h0000;
            if_pc_inc  <= 16'h0000;
            skid_valid <= 1'b0;
            skid_instr <= 16'h0000;
            skid_pc    <= 16'h0000;
        end else if (redirect) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (capture) begin
            if (slot_free) begin
                if_valid  <= 1'b1;
                if_instr  <= imem_data;
                if_pc     <= pc;
                if_pc_inc <= pc_next;
            end else begin
                skid_valid <= 1'b1;
                skid_instr <= imem_data;
                skid_pc    <= pc;
            end
        end else if (!stall) begin
            if (skid_valid) begin
                if_valid   <= 1'b1;
                if_instr   <= skid_instr;
                if_pc      <= skid_pc;
                if_pc_inc  <= skid_pc + 16'd2;
                skid_valid <= 1'b0;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: stream-level model of the delivered instruction
// sequence plus directed scenarios and a randomized phase.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, redirect, imem_ready;
    logic [15:0] redirect_pc, imem_data;
    logic        imem_req, if_valid, halted;
    logic [15:0] imem_addr, if_instr, if_pc, if_pc_inc;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [32768];
    int          lat_mode = 0;   // <0: random 0..3 wait cycles per request
    int          cur_lat  = 0;
    int          wcnt     = 0;

    logic [15:0] exp_pc    = 16'h0000;
    bit          halt_seen = 1'b0;
    int          idle_run  = 0;

    logic        p_req = 1'b0, p_ready = 1'b0, p_rst_n = 1'b0, p_redirect = 1'b0;
    logic [15:0] p_addr = 16'h0000;

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_inc   (if_pc_inc),
        .halted      (halted)
    );

    task automatic chk1(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Compare process, memory model and reference model, all at the falling edge.
    always @(negedge clk) begin
        if (!p_rst_n) begin
            chk1 ("rst_req",    imem_req,  1'b0);
            chk1 ("rst_valid",  if_valid,  1'b0);
            chk1 ("rst_halted", halted,    1'b0);
            chk16("rst_instr",  if_instr,  16'h0000);
            chk16("rst_pc",     if_pc,     16'h0000);
            chk16("rst_pc_inc", if_pc_inc, 16'h0000);
            exp_pc    = 16'h0000;
            halt_seen = 1'b0;
            idle_run  = 0;
        end else begin
            if (if_valid) begin
                chk16("pc_order", if_pc,     exp_pc);
                chk16("instr",    if_instr,  mem[if_pc[15:1]]);
                chk16("pc_inc",   if_pc_inc, if_pc + 16'd2);
            end
            if (halt_seen) begin
                chk1("halt_flag",  halted,   1'b1);
                chk1("halt_req",   imem_req, 1'b0);
                chk1("halt_valid", if_valid, 1'b0);
            end
            if (p_req && !p_ready) begin
                chk1 ("req_hold",  imem_req,  1'b1);
                chk16("addr_hold", imem_addr, p_addr);
            end
            if (p_redirect) begin
                chk1("flush_valid",  if_valid, 1'b0);
                chk1("flush_halted", halted,   1'b0);
            end
        end

        if (!rst_n) begin
            imem_ready = 1'b0;
            wcnt       = 0;
        end else if (imem_req) begin
            if (wcnt == 0) cur_lat = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
            if (wcnt >= cur_lat) begin
                imem_ready = 1'b1;
                wcnt       = 0;
            end else begin
                imem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ready = 1'b0;
        end
        imem_data = mem[imem_addr[15:1]];

        if (rst_n) begin
            if (redirect) begin
                exp_pc    = redirect_pc & 16'hFFFE;
                halt_seen = 1'b0;
                idle_run  = 0;
            end else if (if_valid && !stall) begin
                if (mem[exp_pc[15:1]][15:12] == 4'hF) halt_seen = 1'b1;
                else exp_pc = exp_pc + 16'd2;
                idle_run = 0;
            end else if (!stall && !halt_seen) begin
                idle_run++;
                if (idle_run > 20) begin
                    total++;
                    bad++;
                    $display("FAIL liveness: no delivery in %0d unstalled cycles, want <= 20", idle_run);
                    idle_run = 0;
                end
            end
        end

        p_req      = imem_req;
        p_ready    = imem_ready;
        p_addr     = imem_addr;
        p_rst_n    = rst_n;
        p_redirect = redirect;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int lm);
        lat_mode = lm;
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!if_valid && n < limit) begin
            step();
            n++;
        end
        chk1(name, if_valid, 1'b1);
    endtask

    int hcnt;

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        imem_ready  = 1'b0;
        imem_data   = 16'h0000;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        mem[32767] = 16'h2BAD;

        // 1: zero-wait streaming after reset
        reset_dut(0);
        chk1("t1_idle_req", imem_req, 1'b0);
        step();
        chk1 ("t1_req",  imem_req,  1'b1);
        chk16("t1_addr", imem_addr, 16'h0000);
        step(); chk16("t1_pc0", if_pc, 16'h0000); chk16("t1_inc0", if_pc_inc, 16'h0002);
        step(); chk16("t1_pc1", if_pc, 16'h0002); chk16("t1_inc1", if_pc_inc, 16'h0004);
        step(); chk16("t1_pc2", if_pc, 16'h0004); chk16("t1_inc2", if_pc_inc, 16'h0006);

        // 2: three-cycle memory
        reset_dut(2);
        for (int k = 0; k < 3; k++) begin
            step();
            chk1 ("t2_req",   imem_req,  1'b1);
            chk16("t2_addr",  imem_addr, 16'h0000);
            chk1 ("t2_valid", if_valid,  1'b0);
        end
        step(); chk1("t2_v0", if_valid, 1'b1); chk16("t2_pc0", if_pc, 16'h0000);
        step(); chk1("t2_gap0", if_valid, 1'b0);
        step(); chk1("t2_gap1", if_valid, 1'b0);
        step(); chk1("t2_v1", if_valid, 1'b1); chk16("t2_pc1", if_pc, 16'h0002);

        // 3: stall with a transfer landing in the skid
        reset_dut(0);
        step(); step(); step();
        chk16("t3_pc_pre", if_pc, 16'h0002);
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1 ("t3_hold_v",   if_valid, 1'b1);
            chk16("t3_hold_pc",  if_pc,    16'h0002);
            chk1 ("t3_req_drop", imem_req, 1'b0);
        end
        stall = 1'b0;
        step(); chk16("t3_skid_pc", if_pc, 16'h0004);
        step(); chk16("t3_next_pc", if_pc, 16'h0006);

        // 4: redirect while 0x0008 is outstanding
        reset_dut(2);
        begin
            int n;
            n = 0;
            while (!(imem_req && imem_addr == 16'h0008) && n < 40) begin
                step();
                n++;
            end
            chk16("t4_find_req", imem_addr, 16'h0008);
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk1 ("t4_flush",      if_valid,  1'b0);
        chk1 ("t4_drain_req",  imem_req,  1'b1);
        chk16("t4_drain_addr", imem_addr, 16'h0008);
        step(); chk1("t4_drain_v", if_valid, 1'b0);
        step();
        chk1 ("t4_new_req",  imem_req,  1'b1);
        chk16("t4_new_addr", imem_addr, 16'h0040);
        wait_valid("t4_wait", 10);
        chk16("t4_pc", if_pc, 16'h0040);

        // 5: HLT at 0x0006, then redirect out of halt
        mem[3] = 16'hF000;
        reset_dut(0);
        begin
            int n;
            n = 0;
            while (!(if_valid && if_pc == 16'h0006) && n < 20) begin
                step();
                n++;
            end
        end
        chk16("t5_hlt_pc",    if_pc,    16'h0006);
        chk16("t5_hlt_instr", if_instr, 16'hF000);
        for (int k = 0; k < 10; k++) begin
            step();
            chk1("t5_halted", halted,   1'b1);
            chk1("t5_no_req", imem_req, 1'b0);
        end
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect = 1'b0;
        chk1("t5_unhalt", halted, 1'b0);
        wait_valid("t5_wait", 10);
        chk16("t5_pc", if_pc, 16'h0020);
        mem[3] = 16'h1003;

        // 6: wrap at 0xFFFE (odd redirect target), then reset during DRAIN
        reset_dut(0);
        step(); step(); step();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        step();
        redirect = 1'b0;
        wait_valid("t6_wait", 10);
        chk16("t6_pc0",  if_pc,     16'hFFFE);
        chk16("t6_inc0", if_pc_inc, 16'h0000);
        step();
        chk1 ("t6_v1",   if_valid,  1'b1);
        chk16("t6_pc1",  if_pc,     16'h0000);
        chk16("t6_inc1", if_pc_inc, 16'h0002);

        reset_dut(3);
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect = 1'b0;
        chk1 ("t6_drain_req",  imem_req,  1'b1);
        chk16("t6_drain_addr", imem_addr, 16'h0000);
        rst_n = 1'b0;
        step();
        chk1 ("t6_rst_req",   imem_req,  1'b0);
        chk1 ("t6_rst_valid", if_valid,  1'b0);
        chk16("t6_rst_pc",    if_pc,     16'h0000);
        chk16("t6_rst_inc",   if_pc_inc, 16'h0000);
        rst_n = 1'b1;

        // Randomized phase against the model
        reset_dut(-1);
        hcnt = 0;
        for (int n = 0; n < 4000; n++) begin
            step();
            rst_n = ($urandom_range(499) != 0);
            stall = ($urandom_range(2) == 0);
            if (halted) hcnt++;
            else hcnt = 0;
            redirect = ($urandom_range(29) == 0) || (hcnt > 3);
            case ($urandom_range(3))
                0:       redirect_pc = ($urandom_range(1) == 0) ? 16'hFFFE : 16'hFFFF;
                default: redirect_pc = 16'($urandom);
            endcase
            if (redirect) hcnt = 0;
        end
        rst_n    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
